wb_timer: RTL

WB_TIMER -- requirements
Module: wb_timer

---
 rtl/wb_timer_if.sv | 33 +++
 rtl/wb_timer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/wb_timer_if.sv
// ============================================================================
// Module   : wishbone_if
// Purpose  : Pipelined Wishbone bus bundle (32-bit data, byte selects).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wishbone_if;
  logic        cyc;
  logic        stb;
  logic        lock;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rty;
  logic        ack;
  logic        stall;
  logic        err;

  modport SLAVE (
    input  cyc, stb, lock, we, addr, sel, wdata,
    output rdata, rty, ack, stall, err
  );

  modport MASTER (
    output cyc, stb, lock, we, addr, sel, wdata,
    input  rdata, rty, ack, stall, err
  );
endinterface

`default_nettype wire

// File: rtl/wb_timer.sv
// ============================================================================
// Module   : wb_timer
// Purpose  : Machine timer (64-bit mtime / mtimecmp) on a pipelined Wishbone
//            responder, with a programmable prescaler and a level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  wishbone_if.SLAVE  wb_if,
  output logic       timer_int_o
);

  localparam logic [15:0] c_PRESC_MAX = 16'(PRESCALE - 1);
  localparam logic [63:0] c_CMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF;

  // Register state
  logic [15:0] r_presc;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_int;

  // Decode / datapath wires
  logic        w_acc;
  logic        w_addr_ok;
  logic        w_wr;
  logic        w_tick;
  logic [1:0]  w_idx;
  logic [31:0] w_bmask;
  logic [31:0] w_rd_val;
  logic [63:0] w_mtime_nxt;
  logic [63:0] w_mtimecmp_nxt;

  // Lock and the upper address bits carry no meaning here
  logic w_unused;
  assign w_unused = &{1'b0, wb_if.lock, wb_if.addr[31:4]};

  // A request is taken whenever cyc and stb are both high; never stalls
  assign w_acc     = wb_if.cyc & wb_if.stb;
  assign w_addr_ok = (wb_if.addr[1:0] == 2'b00);
  assign w_idx     = wb_if.addr[3:2];
  // A write with no byte lanes selected is acknowledged but touches nothing,
  // so it must not block the mtime increment either
  assign w_wr      = w_acc & w_addr_ok & wb_if.we & (|wb_if.sel);
  assign w_tick    = (r_presc == c_PRESC_MAX);

  assign w_bmask = {{8{wb_if.sel[3]}}, {8{wb_if.sel[2]}},
                    {8{wb_if.sel[1]}}, {8{wb_if.sel[0]}}};

  // Read mux: addressed 32-bit half of mtime / mtimecmp
  always_comb begin
    w_rd_val = 32'd0;
    case (w_idx)
      2'd0:    w_rd_val = r_mtime[31:0];
      2'd1:    w_rd_val = r_mtime[63:32];
      2'd2:    w_rd_val = r_mtimecmp[31:0];
      default: w_rd_val = r_mtimecmp[63:32];
    endcase
  end

  // Next mtime: a software write wins over the tick and freezes both halves
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_wr && (w_idx == 2'd0)) begin
      w_mtime_nxt[31:0]  = (r_mtime[31:0] & ~w_bmask) | (wb_if.wdata & w_bmask);
    end else if (w_wr && (w_idx == 2'd1)) begin
      w_mtime_nxt[63:32] = (r_mtime[63:32] & ~w_bmask) | (wb_if.wdata & w_bmask);
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end
  end

  // Next mtimecmp: byte-lane merge of the written half
  always_comb begin
    w_mtimecmp_nxt = r_mtimecmp;
    if (w_wr && (w_idx == 2'd2)) begin
      w_mtimecmp_nxt[31:0]  = (r_mtimecmp[31:0] & ~w_bmask) | (wb_if.wdata & w_bmask);
    end else if (w_wr && (w_idx == 2'd3)) begin
      w_mtimecmp_nxt[63:32] = (r_mtimecmp[63:32] & ~w_bmask) | (wb_if.wdata & w_bmask);
    end
  end

  // Prescaler counts 0..PRESCALE-1 and wraps on the tick
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_presc <= 16'd0;
    end else if (w_tick) begin
      r_presc <= 16'd0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // Timer registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= c_CMP_RST;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
    end
  end

  // One-cycle response pipeline; read data is zero unless a read was taken
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack   <= w_acc & w_addr_ok;
      r_err   <= w_acc & ~w_addr_ok;
      r_rdata <= (w_acc && w_addr_ok && !wb_if.we) ? w_rd_val : 32'd0;
    end
  end

  // Interrupt level compares the current register values
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_int <= 1'b0;
    end else begin
      r_int <= (r_mtime >= r_mtimecmp);
    end
  end

  // A response is dropped if the master has released cyc when it is due
  assign wb_if.ack   = r_ack & wb_if.cyc;
  assign wb_if.err   = r_err & wb_if.cyc;
  assign wb_if.rdata = r_rdata;
  assign wb_if.stall = 1'b0;
  assign wb_if.rty   = 1'b0;
  assign timer_int_o = r_int;

endmodule

`default_nettype wire
